// File: rtl/fabric_clk_div_ccc_pkg.sv
// Shared defaults and helpers for the fabric clock-enable divider block.
package fabric_ccc_pkg;

    localparam int DIVW_DEF        = 5;
    localparam int DEFAULT_DIV_DEF = 3;
    localparam bit DEFAULT_EN_DEF  = 1'b1;
    localparam int LOCK_CYCLES_DEF = 16;

    // A divisor field d divides the fabric clock by d+1.
    function automatic int div_ratio(input int field);
        return field + 1;
    endfunction

    // Width of the channel-select field; never narrower than one bit.
    function automatic int ch_idx_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/fabric_clk_div_ccc_chan.sv
// One divider channel: period counter, shadow config, apply point, CE and TOG outputs.
module clk_div_chan
    import fabric_ccc_pkg::*;
#(
    parameter int DIVW        = DIVW_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    parameter bit DEFAULT_EN  = DEFAULT_EN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sync,
    input  logic            wr,
    input  logic [DIVW-1:0] wr_div,
    input  logic            wr_en,
    output logic            ce,
    output logic            tog,
    output logic            pending,
    output logic            applied
);

    localparam logic [DIVW-1:0] RST_DIV = DIVW'(DEFAULT_DIV);

    logic [DIVW-1:0] cnt_q, cnt_d;
    logic [DIVW-1:0] div_q, div_d;
    logic [DIVW-1:0] sh_div_q, sh_div_d;
    logic            en_q, en_d;
    logic            sh_en_q, sh_en_d;
    logic            pend_q, pend_d;
    logic            ce_q, ce_d;
    logic            tog_q, tog_d;

    // Next-state: count the period, apply the shadow only at a period boundary
    // (or right away when idle/bypassed, or on sync), then derive CE and TOG.
    // In bypass the counter sits at 0 == div, so the wrap compare fires every cycle.
    always_comb begin
        cnt_d    = '0;
        ce_d     = 1'b0;
        applied  = pend_q && (sync || !en_q || (cnt_q == div_q));
        if (sync || !en_q) begin
            cnt_d = '0;
            ce_d  = 1'b0;
        end else if (cnt_q == div_q) begin
            cnt_d = '0;
            ce_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        div_d = applied ? sh_div_q : div_q;
        en_d  = applied ? sh_en_q  : en_q;
        if (applied) begin
            cnt_d = '0;
        end
        tog_d    = en_d && (div_d != '0) && (cnt_d <= (div_d >> 1));
        sh_div_d = wr ? wr_div : sh_div_q;
        sh_en_d  = wr ? wr_en  : sh_en_q;
        // A write landing on the apply cycle re-arms pending for the next boundary.
        pend_d   = wr || (pend_q && !applied);
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            div_q    <= RST_DIV;
            en_q     <= DEFAULT_EN;
            sh_div_q <= RST_DIV;
            sh_en_q  <= DEFAULT_EN;
            pend_q   <= 1'b0;
            ce_q     <= 1'b0;
            tog_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            en_q     <= en_d;
            sh_div_q <= sh_div_d;
            sh_en_q  <= sh_en_d;
            pend_q   <= pend_d;
            ce_q     <= ce_d;
            tog_q    <= tog_d;
        end
    end

    assign ce      = ce_q;
    assign tog     = tog_q;
    assign pending = pend_q;

endmodule

// File: rtl/fabric_clk_div_ccc.sv
// NCH clock-enable divider channels off the fabric clock, with config decode,
// common SYNC restart and a LOCK flag once every channel runs its programmed setting.
module fabric_clk_div_ccc
    import fabric_ccc_pkg::*;
#(
    parameter int NCH         = 3,
    parameter int DIVW        = DIVW_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF,
    parameter bit DEFAULT_EN  = DEFAULT_EN_DEF,
    parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     SYNC,
    input  logic                     CFG_WE,
    input  logic [ch_idx_w(NCH)-1:0] CFG_CH,
    input  logic [DIVW-1:0]          CFG_DIV,
    input  logic                     CFG_EN,
    output logic [NCH-1:0]           CE,
    output logic [NCH-1:0]           TOG,
    output logic [NCH-1:0]           PENDING,
    output logic                     LOCK
);

    localparam int              LCW      = $clog2(LOCK_CYCLES + 1);
    localparam logic [LCW-1:0]  LOCK_MAX = LCW'(LOCK_CYCLES);

    logic            cfg_valid;
    logic [NCH-1:0]  wr_vec;
    logic [NCH-1:0]  applied;
    logic            lock_clr;
    logic [LCW-1:0]  lock_cnt_q, lock_cnt_d;
    logic            lock_q, lock_d;

    // Config decode: out-of-range channel indices are dropped entirely.
    always_comb begin
        cfg_valid = CFG_WE && (32'(CFG_CH) < NCH);
        wr_vec    = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_vec[i] = cfg_valid && (32'(CFG_CH) == i);
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .DIVW        (DIVW),
            .DEFAULT_DIV (DEFAULT_DIV),
            .DEFAULT_EN  (DEFAULT_EN)
        ) u_chan (
            .clk     (CLK),
            .rst_n   (RESET_N),
            .sync    (SYNC),
            .wr      (wr_vec[g]),
            .wr_div  (CFG_DIV),
            .wr_en   (CFG_EN),
            .ce      (CE[g]),
            .tog     (TOG[g]),
            .pending (PENDING[g]),
            .applied (applied[g])
        );
    end

    // Lock counter: any config change restarts the stability window; it only
    // advances while nothing is pending and saturates at the lock threshold.
    always_comb begin
        lock_clr   = cfg_valid || SYNC || (|applied);
        lock_cnt_d = lock_cnt_q;
        if (lock_clr) begin
            lock_cnt_d = '0;
        end else if (!(|PENDING) && (lock_cnt_q != LOCK_MAX)) begin
            lock_cnt_d = lock_cnt_q + 1'b1;
        end
        lock_d = (lock_cnt_d == LOCK_MAX);
    end

    // Lock state registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign LOCK = lock_q;

endmodule

// File: tb/tb_fabric_clk_div_ccc.sv
// Self-checking bench for fabric_clk_div_ccc with a period-level reference model.
module tb_fabric_clk_div_ccc;
    import fabric_ccc_pkg::*;

    localparam int NCH   = 3;
    localparam int LOCKN = 16;

    logic           CLK = 1'b0;
    logic           RESET_N = 1'b0;
    logic           SYNC = 1'b0;
    logic           CFG_WE = 1'b0;
    logic [1:0]     CFG_CH = '0;
    logic [4:0]     CFG_DIV = '0;
    logic           CFG_EN = 1'b0;
    logic [NCH-1:0] CE, TOG, PENDING;
    logic           LOCK;

    int checks = 0;
    int errors = 0;

    // Reference model state: position within the current period, active and shadow config.
    int             m_div[NCH];
    bit             m_en[NCH];
    int             m_pos[NCH];
    int             m_sdiv[NCH];
    bit             m_sen[NCH];
    bit             m_pend[NCH];
    int             m_lcnt;
    logic [NCH-1:0] x_ce, x_tog;
    logic [3*NCH:0] got, want;

    fabric_clk_div_ccc #(.NCH(NCH)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .SYNC    (SYNC),
        .CFG_WE  (CFG_WE),
        .CFG_CH  (CFG_CH),
        .CFG_DIV (CFG_DIV),
        .CFG_EN  (CFG_EN),
        .CE      (CE),
        .TOG     (TOG),
        .PENDING (PENDING),
        .LOCK    (LOCK)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i]  = 3;
            m_en[i]   = 1'b1;
            m_pos[i]  = 0;
            m_sdiv[i] = 3;
            m_sen[i]  = 1'b1;
            m_pend[i] = 1'b0;
        end
        m_lcnt = 0;
        x_ce   = '0;
        x_tog  = '0;
    endtask

    // One clock edge of the reference model, using the inputs present at that edge.
    task automatic model_step();
        bit any_pend;
        bit any_apply;
        bit valid;
        any_pend  = 1'b0;
        any_apply = 1'b0;
        valid     = CFG_WE && (CFG_CH < NCH);
        for (int i = 0; i < NCH; i++) any_pend |= m_pend[i];
        for (int i = 0; i < NCH; i++) begin
            int ratio;
            int r2;
            bit running;
            bit done;
            bit apply;
            ratio   = div_ratio(m_div[i]);
            running = m_en[i] && (ratio > 1);
            done    = running && (m_pos[i] == ratio - 1);
            apply   = m_pend[i] && (SYNC || !m_en[i] || ratio == 1 || done);
            x_ce[i] = !SYNC && m_en[i] && (ratio == 1 || done);
            m_pos[i] = (SYNC || !running || done) ? 0 : m_pos[i] + 1;
            if (apply) begin
                m_div[i]  = m_sdiv[i];
                m_en[i]   = m_sen[i];
                m_pos[i]  = 0;
                m_pend[i] = 1'b0;
                any_apply = 1'b1;
            end
            if (valid && CFG_CH == i) begin
                m_sdiv[i] = int'(CFG_DIV);
                m_sen[i]  = CFG_EN;
                m_pend[i] = 1'b1;
            end
            r2 = div_ratio(m_div[i]);
            x_tog[i] = m_en[i] && (r2 > 1) && (m_pos[i] < (r2 + 1) / 2);
        end
        if (valid || SYNC || any_apply) m_lcnt = 0;
        else if (!any_pend && m_lcnt < LOCKN) m_lcnt++;
    endtask

    function automatic logic [3*NCH:0] expv();
        logic [NCH-1:0] p;
        for (int i = 0; i < NCH; i++) p[i] = m_pend[i];
        return {x_ce, x_tog, p, (m_lcnt == LOCKN)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        CFG_WE = 1'b0;
        SYNC   = 1'b0;
    endtask

    task automatic cfg(input int ch, input int dv, input bit en);
        CFG_WE  = 1'b1;
        CFG_CH  = 2'(ch);
        CFG_DIV = 5'(dv);
        CFG_EN  = en;
    endtask

    task automatic test_reset();
        @(posedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({CE, TOG, PENDING, LOCK} !== '0) begin
            errors++;
            $display("FAIL reset_async got=%b want=0", {CE, TOG, PENDING, LOCK});
        end
        model_reset();
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            logic [NCH-1:0] ce_w, tog_w;
            tick();
            ce_w  = (e % 4 == 0) ? '1 : '0;
            tog_w = ((e % 4) <= 1) ? '1 : '0;
            got = {CE, TOG, PENDING, LOCK}; want = expv(); checks++;
            if (got !== want) begin errors++; $display("FAIL reset_model e=%0d got=%b want=%b", e, got, want); end
            checks++;
            if (CE !== ce_w) begin errors++; $display("FAIL reset_ce e=%0d got=%b want=%b", e, CE, ce_w); end
            checks++;
            if (TOG !== tog_w) begin errors++; $display("FAIL reset_tog e=%0d got=%b want=%b", e, TOG, tog_w); end
            checks++;
            if (LOCK !== (e >= 16)) begin errors++; $display("FAIL reset_lock e=%0d got=%b want=%b", e, LOCK, (e >= 16)); end
        end
    endtask

    task automatic test_mid_write();
        int n;
        n = 0;
        while (m_pos[0] != 1 && n < 20) begin tick(); n++; end
        checks++;
        if (m_pos[0] != 1) begin errors++; $display("FAIL mid_wait timeout got=%0d want=1", m_pos[0]); end
        cfg(0, 5, 1'b1);
        tick();
        got = {CE, TOG, PENDING, LOCK}; want = expv(); checks++;
        if (got !== want || PENDING[0] !== 1'b1 || LOCK !== 1'b0) begin
            errors++; $display("FAIL mid_write got=%b want=%b", got, want);
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            got = {CE, TOG, PENDING, LOCK}; want = expv(); checks++;
            if (got !== want) begin errors++; $display("FAIL mid_model k=%0d got=%b want=%b", k, got, want); end
            if (k == 2 || k == 8) begin
                checks++;
                if (CE[0] !== 1'b1) begin errors++; $display("FAIL mid_ce k=%0d got=%b want=1", k, CE[0]); end
            end
            if (k == 2) begin
                checks++;
                if (PENDING[0] !== 1'b0) begin errors++; $display("FAIL mid_pend got=%b want=0", PENDING[0]); end
            end
            if (k == 17 || k == 18) begin
                checks++;
                if (LOCK !== (k == 18)) begin errors++; $display("FAIL mid_lock k=%0d got=%b want=%b", k, LOCK, (k == 18)); end
            end
        end
    endtask

    task automatic test_bypass();
        int n;
        cfg(1, 0, 1'b1);
        tick();
        n = 0;
        while (PENDING[1] !== 1'b0 && n < 8) begin
            tick(); n++;
            got = {CE, TOG, PENDING, LOCK}; want = expv(); checks++;
            if (got !== want) begin errors++; $display("FAIL byp_wait got=%b want=%b", got, want); end
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            got = {CE, TOG, PENDING, LOCK}; want = expv(); checks++;
            if (got !== want) begin errors++; $display("FAIL byp_model k=%0d got=%b want=%b", k, got, want); end
            checks++;
            if (CE[1] !== 1'b1 || TOG[1] !== 1'b0) begin
                errors++; $display("FAIL byp_ch1 k=%0d got ce=%b tog=%b want ce=1 tog=0", k, CE[1], TOG[1]);
            end
        end
    endtask

    task automatic test_disabled_apply();
        int n;
        cfg(2, 3, 1'b0);
        tick();
        n = 0;
        while (PENDING[2] !== 1'b0 && n < 8) begin tick(); n++; end
        for (int k = 0; k < 3; k++) begin
            tick();
            got = {CE, TOG, PENDING, LOCK}; want = expv(); checks++;
            if (got !== want || CE[2] !== 1'b0) begin errors++; $display("FAIL dis_off k=%0d got=%b want=%b", k, got, want); end
        end
        cfg(2, 7, 1'b1);
        tick();
        for (int k = 1; k <= 10; k++) begin
            tick();
            got = {CE, TOG, PENDING, LOCK}; want = expv(); checks++;
            if (got !== want) begin errors++; $display("FAIL dis_model k=%0d got=%b want=%b", k, got, want); end
            if (k == 1) begin
                checks++;
                if (PENDING[2] !== 1'b0) begin errors++; $display("FAIL dis_pend got=%b want=0", PENDING[2]); end
            end
            if (k <= 9) begin
                checks++;
                if (CE[2] !== (k == 9)) begin errors++; $display("FAIL dis_ce k=%0d got=%b want=%b", k, CE[2], (k == 9)); end
            end
        end
    endtask

    task automatic test_sync();
        int n;
        n = 0;
        while (m_pos[0] != 2 && n < 12) begin tick(); n++; end
        checks++;
        if (m_pos[0] != 2) begin errors++; $display("FAIL sync_wait timeout got=%0d want=2", m_pos[0]); end
        SYNC = 1'b1;
        tick();
        checks++;
        if (CE !== 3'b000 || LOCK !== 1'b0) begin errors++; $display("FAIL sync_edge got ce=%b lock=%b want ce=000 lock=0", CE, LOCK); end
        for (int k = 1; k <= 12; k++) begin
            tick();
            got = {CE, TOG, PENDING, LOCK}; want = expv(); checks++;
            if (got !== want) begin errors++; $display("FAIL sync_model k=%0d got=%b want=%b", k, got, want); end
            if (k == 6 || k == 8) begin
                logic [NCH-1:0] ce_w;
                ce_w = (k == 6) ? 3'b011 : 3'b110;
                checks++;
                if (CE !== ce_w) begin errors++; $display("FAIL sync_align k=%0d got=%b want=%b", k, CE, ce_w); end
            end
        end
    endtask

    task automatic test_bad_channel();
        int n;
        n = 0;
        while (LOCK !== 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (LOCK !== 1'b1) begin errors++; $display("FAIL bad_lockwait got=%b want=1", LOCK); end
        cfg(3, 9, 1'b0);
        tick();
        checks++;
        if (PENDING !== 3'b000 || LOCK !== 1'b1) begin errors++; $display("FAIL bad_ch got pend=%b lock=%b want pend=000 lock=1", PENDING, LOCK); end
        for (int k = 0; k < 8; k++) begin
            tick();
            got = {CE, TOG, PENDING, LOCK}; want = expv(); checks++;
            if (got !== want) begin errors++; $display("FAIL bad_model k=%0d got=%b want=%b", k, got, want); end
        end
    endtask

    task automatic test_back_to_back();
        cfg(0, 2, 1'b1);
        tick();
        cfg(0, 4, 1'b1);
        tick();
        for (int k = 0; k < 20; k++) begin
            if (k == 3) cfg(0, 1, 1'b1);
            tick();
            got = {CE, TOG, PENDING, LOCK}; want = expv(); checks++;
            if (got !== want) begin errors++; $display("FAIL b2b_model k=%0d got=%b want=%b", k, got, want); end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                CFG_WE  = 1'b1;
                CFG_CH  = 2'($urandom_range(0, 3));
                CFG_DIV = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 6));
                CFG_EN  = ($urandom_range(0, 4) != 0);
            end
            if ($urandom_range(0, 29) == 0) SYNC = 1'b1;
            tick();
            got = {CE, TOG, PENDING, LOCK}; want = expv(); checks++;
            if (got !== want) begin errors++; $display("FAIL rand_model n=%0d got=%b want=%b", n, got, want); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mid_write();
        test_bypass();
        test_disabled_apply();
        test_sync();
        test_bad_channel();
        test_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
